// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: 640x480@60 raster constants and the scanner state type.
package vga_scan_pkg;
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  typedef enum logic {OFF, ON} scan_state_t;
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: 25 MHz pixel enable, raster counters, raw syncs/blank and frame strobes.
module vga_timing_counter
  import vga_scan_pkg::*;
#(
  parameter int H_ACT   = H_VIS,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_VIS,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       blank_n_raw,
  output logic       frame_end,
  output logic       frame_start,
  output logic       clock_vga
);
  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [9:0] HS_ON  = 10'(H_ACT + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_ACT + H_FRONT + H_PULSE);
  localparam logic [9:0] VS_ON  = 10'(V_ACT + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_ACT + V_FRONT + V_PULSE);
  logic h_last, v_last;
  always_comb begin
    h_last      = hcnt == H_LAST;
    v_last      = vcnt == V_LAST;
    frame_end   = pix_en && h_last && v_last;
    hs_raw      = !(hcnt >= HS_ON && hcnt < HS_OFF);
    vs_raw      = !(vcnt >= VS_ON && vcnt < VS_OFF);
    blank_n_raw = hcnt < 10'(H_ACT) && vcnt < 10'(V_ACT);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pix_en      <= 1'b0;
      clock_vga   <= 1'b0;
      frame_start <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
    end else begin
      pix_en      <= !pix_en;
      clock_vga   <= !pix_en;
      frame_start <= frame_end;
      if (pix_en) begin
        hcnt <= h_last ? '0 : hcnt + 10'd1;
        if (h_last) vcnt <= v_last ? '0 : vcnt + 10'd1;
      end
    end
endmodule

// File: rtl/vga_image_scanner.sv
// vga_image_scanner: VGA raster scan of a fixed image window with registered memory fetch.
// Optional white one-pixel frame around the window with VGA_SCAN_BORDER_EN.
module vga_image_scanner
  import vga_scan_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int X0      = 192,
  parameter int Y0      = 112,
  parameter int ADDR_W  = 18,
  parameter int H_ACT   = H_VIS,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_VIS,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        img_data,
  output logic [ADDR_W-1:0] img_addr,
  output logic              img_rd,
  output logic [7:0]        gray,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              clockVGA,
  output logic              frame_start
);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [9:0] XL = 10'(X0);
  localparam logic [9:0] XH = 10'(X0 + IMG_W);
  localparam logic [9:0] YL = 10'(Y0);
  localparam logic [9:0] YH = 10'(Y0 + IMG_H);
  scan_state_t state, state_n;
  logic pix_en, hs_raw, vs_raw, blank_n_raw, frame_end, in_win, ring, on;
  logic [9:0] hcnt, vcnt;
  logic [ADDR_W-1:0] acnt;
  logic win_q, ring_q, hs_q, vs_q, blank_q;
  vga_timing_counter #(
    .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_PULSE(H_PULSE), .H_BACK(H_BACK),
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_PULSE(V_PULSE), .V_BACK(V_BACK)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .blank_n_raw(blank_n_raw),
    .frame_end(frame_end), .frame_start(frame_start), .clock_vga(clockVGA)
  );
  assign on     = state == ON;
  assign in_win = hcnt >= XL && hcnt < XH && vcnt >= YL && vcnt < YH;
`ifdef VGA_SCAN_BORDER_EN
  localparam logic [9:0] XR = 10'(X0 - 1);
  localparam logic [9:0] YR = 10'(Y0 - 1);
  assign ring = ((vcnt == YR || vcnt == YH) && hcnt >= XR && hcnt <= XH) ||
                ((hcnt == XR || hcnt == XH) && vcnt >= YL && vcnt < YH);
`else
  assign ring = 1'b0;
`endif
  // enable only takes effect on the frame boundary so a frame is never torn
  always_comb state_n = frame_end ? (enable ? ON : OFF) : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= OFF;
    else        state <= state_n;
  // pixel stage on pix_en edges, fetch/output stage on the opposite edges
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acnt        <= '0;
      img_addr    <= '0;
      img_rd      <= 1'b0;
      gray        <= 8'h00;
      win_q       <= 1'b0;
      ring_q      <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      img_rd <= !pix_en && on && in_win;
      if (pix_en) begin
        win_q   <= on && in_win;
        ring_q  <= on && ring;
        hs_q    <= hs_raw;
        vs_q    <= vs_raw;
        blank_q <= blank_n_raw;
        acnt    <= frame_end ? '0 : (in_win && acnt != A_LAST) ? acnt + ADDR_W'(1) : acnt;
      end else begin
        img_addr    <= acnt;
        gray        <= win_q ? img_data : ring_q ? 8'hFF : 8'h00;
        vga_hs      <= hs_q;
        vga_vs      <= vs_q;
        vga_blank_n <= blank_q;
      end
    end
endmodule

// File: tb/tb_vga_image_scanner.sv
// tb_vga_image_scanner: scaled raster, random enable schedule and memory contents vs a cycle-count model.
module tb_vga_image_scanner;
  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PPF = HT * VT;
  localparam int FCLK = 2 * PPF;
  localparam int IW = 16, IH = 8, X0 = 10, Y0 = 12;
  localparam bit BORDER =
`ifdef VGA_SCAN_BORDER_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 0, reset = 1, enable = 0;
  logic [7:0] img_data = 0, gray;
  logic [17:0] img_addr;
  logic img_rd, vga_hs, vga_vs, vga_blank_n, clockVGA, frame_start;
  int checks = 0, errs = 0, n = 0;
  bit fon[64];
  logic [7:0] key;
  vga_image_scanner #(
    .IMG_W(IW), .IMG_H(IH), .X0(X0), .Y0(Y0), .ADDR_W(18),
    .H_ACT(HA), .H_FRONT(HF), .H_PULSE(HS), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_PULSE(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .img_data(img_data),
    .img_addr(img_addr), .img_rd(img_rd), .gray(gray), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .clockVGA(clockVGA),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_f(int a);
    return 8'(a) ^ key;
  endfunction
  always @(posedge clk) img_data <= mem_f(int'(img_addr));
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit win(int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH;
  endfunction
  function automatic bit ring(int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return ((v == Y0 - 1 || v == Y0 + IH) && h >= X0 - 1 && h <= X0 + IW) ||
           ((h == X0 - 1 || h == X0 + IW) && v >= Y0 && v < Y0 + IH);
  endfunction
  function automatic int addr(int p);
    return ((p / HT) % VT - Y0) * IW + (p % HT - X0);
  endfunction
  // n = clk edges since reset release; pixel p is being fetched, pixel q is on the outputs
  function automatic logic [30:0] model(int cyc);
    int p, q, h, v;
    bit rd, hs, vs, bl;
    logic [7:0] g;
    p = cyc / 2;
    q = cyc >= 3 ? (cyc - 3) / 2 : -1;
    rd = (cyc % 2 == 1) && fon[p / PPF] && win(p);
    g = 8'h00; hs = 1; vs = 1; bl = 0;
    if (q >= 0) begin
      h = q % HT;
      v = (q / HT) % VT;
      hs = !(h >= HA + HF && h < HA + HF + HS);
      vs = !(v >= VA + VF && v < VA + VF + VS);
      bl = h < HA && v < VA;
      if (fon[q / PPF] && win(q)) g = mem_f(addr(q));
      else if (BORDER && fon[q / PPF] && ring(q)) g = 8'hFF;
    end
    return {rd, rd ? 18'(addr(p)) : 18'd0, g, hs, vs, bl, cyc % 2 == 1, cyc > 0 && cyc % FCLK == 0};
  endfunction
  always @(posedge clk) begin
    logic [30:0] exp_v, act_v;
    #1;
    if (!reset) begin
      n = 0;
      fon[0] = 0;
      exp_v = {1'b0, 18'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      n++;
      if (n % FCLK == 0 && n / FCLK < 64) fon[n / FCLK] = enable;
      exp_v = model(n);
    end
    act_v = {img_rd, img_rd ? img_addr : 18'd0, gray, vga_hs, vga_vs, vga_blank_n, clockVGA, frame_start};
    chk($sformatf("outputs n=%0d {rd,addr,gray,hs,vs,blank_n,clk,fs}", n), act_v, exp_v);
    if (errs > 100) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
    end
  end
  int gc = 0, hs_w, vs_w, hs_fall, fs_t, rd_cnt, last_addr;
  bit hs_p, vs_p;
  always @(posedge clk) begin
    #1;
    gc++;
    if (!reset) begin
      hs_w = 0; vs_w = 0; hs_fall = -1; fs_t = -1; rd_cnt = 0; hs_p = 1; vs_p = 1;
    end else begin
      if (!vga_hs) hs_w++;
      else if (!hs_p) begin chk("hs_low_width", hs_w, 16); hs_w = 0; end
      if (!vga_hs && hs_p) begin
        if (hs_fall >= 0) chk("hs_period", gc - hs_fall, 112);
        hs_fall = gc;
      end
      if (!vga_vs) vs_w++;
      else if (!vs_p) begin chk("vs_low_width", vs_w, 224); vs_w = 0; end
      if (frame_start) begin
        if (fs_t >= 0) chk("frame_period", gc - fs_t, 4144);
        fs_t = gc;
        if (rd_cnt > 0) begin
          chk("reads_per_frame", rd_cnt, 128);
          chk("last_fetch_addr", last_addr, 127);
        end
        rd_cnt = 0;
      end
      if (img_rd) begin
        if (rd_cnt == 0) chk("first_fetch_addr", img_addr, 0);
        last_addr = int'(img_addr);
        rd_cnt++;
      end
      hs_p = vga_hs;
      vs_p = vga_vs;
    end
  end
  task automatic chk_reset_vals(string nm);
    chk(nm, {img_addr, img_rd, gray, vga_hs, vga_vs, vga_blank_n, clockVGA, frame_start},
        {18'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    key = 8'($urandom);
    #1 reset = 0;
    #1 chk_reset_vals("reset_values");
    repeat (3) @(negedge clk);
    reset = 1;
    wait (n >= FCLK + 200 + int'($urandom_range(0, FCLK - 400)));
    enable = 1;
    wait (n >= 3 * FCLK + 2 * ((Y0 + 3) * HT + X0 + 5));
    enable = 0;
    for (int f = 4; f < 7; f++) begin
      wait (n >= f * FCLK + 200 + int'($urandom_range(0, FCLK - 400)));
      enable = 1'($urandom_range(0, 1));
    end
    wait (n >= 7 * FCLK + FCLK / 2);
    enable = 1;
    wait (n >= 8 * FCLK + 2 * ((Y0 + 2) * HT + X0 + 3));
    #2 reset = 0;
    #1 chk_reset_vals("midframe_reset_values");
    repeat (5) @(negedge clk);
    reset = 1;
    wait (n >= 2 * FCLK + 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
